// File: rtl/stack_pointer_unit.sv
// 8080 stack pointer and call/return engine: byte-serial SP load, two-byte push
// (MSB at SP-1, then LSB at SP-2) and pop replayed LSB-then-MSB onto the data bus.
module stack_pointer_unit (
    input  logic        clk50M_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [7:0]  dat_i,
    output logic [7:0]  dat_o,
    output logic        dat_oe_o,
    output logic [15:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    output logic        mem_we_o,
    output logic        mem_re_o,
    input  logic [7:0]  mem_rdata_i,
    input  logic        mem_ready_i,
    output logic [15:0] sp_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [3:0] {
        IDLE, LD_LO, LD_HI, CAP_LO, CAP_HI, WR_HI, WR_LO, RD_LO, RD_HI, DRV_LO, DRV_HI
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] sp_q, sp_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic        done_q, done_d;

    always_comb begin
        state_d  = state_q;
        sp_d     = sp_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        done_d   = 1'b0;
        dat_o    = 8'h00;
        dat_oe_o = 1'b0;
        mem_we_o = 1'b0;
        mem_re_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_i) begin
                    state_d = LD_LO;
                end else if (push_i) begin
                    state_d = CAP_LO;
                end else if (pop_i) begin
                    state_d = RD_LO;
                    addr_d  = sp_q;
                end
            end
            LD_LO: begin
                sp_d[7:0] = dat_i;
                state_d   = LD_HI;
            end
            LD_HI: begin
                sp_d[15:8] = dat_i;
                state_d    = IDLE;
                done_d     = 1'b1;
            end
            CAP_LO: begin
                lo_d    = dat_i;
                state_d = CAP_HI;
            end
            CAP_HI: begin
                // The MSB goes straight to the write-data register so WR_HI can start immediately.
                hi_d    = dat_i;
                addr_d  = sp_q - 16'd1;
                wdata_d = dat_i;
                state_d = WR_HI;
            end
            WR_HI: begin
                mem_we_o = 1'b1;
                if (mem_ready_i) begin
                    addr_d  = sp_q - 16'd2;
                    wdata_d = lo_q;
                    state_d = WR_LO;
                end
            end
            WR_LO: begin
                mem_we_o = 1'b1;
                if (mem_ready_i) begin
                    sp_d    = sp_q - 16'd2;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            RD_LO: begin
                mem_re_o = 1'b1;
                if (mem_ready_i) begin
                    lo_d    = mem_rdata_i;
                    addr_d  = sp_q + 16'd1;
                    state_d = RD_HI;
                end
            end
            RD_HI: begin
                mem_re_o = 1'b1;
                if (mem_ready_i) begin
                    hi_d    = mem_rdata_i;
                    sp_d    = sp_q + 16'd2;
                    state_d = DRV_LO;
                end
            end
            DRV_LO: begin
                dat_o    = lo_q;
                dat_oe_o = 1'b1;
                state_d  = DRV_HI;
            end
            DRV_HI: begin
                dat_o    = hi_q;
                dat_oe_o = 1'b1;
                state_d  = IDLE;
                done_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk50M_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sp_q    <= 16'h0000;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    // Byte holding registers are only observed through gated outputs, so they skip reset.
    always_ff @(posedge clk50M_i) begin
        lo_q <= lo_d;
        hi_q <= hi_d;
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign sp_o        = sp_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

endmodule
